// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter/sequencer for the shared memory bus: grants one master, strobes memory for
// WAIT_STATES extra cycles, returns read data and a one-cycle ack. MEM_ARB_LOCK_EN adds lock inputs.
//
// state | meaning
// IDLE  | arbitrate pending requests, latch the winner onto the memory bus
// BUSY  | strobe asserted, wait-state down-counter running to zero
// DONE  | owner ack pulse, read data valid, grant still shown
module mem_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
`ifdef MEM_ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        gnt,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             win_valid;
  logic             pick_m1;

`ifdef MEM_ARB_LOCK_EN
  logic lock_hold;
  logic lock_own;
  logic owner_lock;

  assign owner_lock = gnt[1] ? m1_lock : m0_lock;
`endif

  // Contention goes to the master that did not win last time; a single requester always wins.
  always_comb begin
    win_valid = m0_req | m1_req;
    pick_m1   = m1_req;
    if (m0_req && m1_req) begin
      pick_m1 = ~last;
    end
`ifdef MEM_ARB_LOCK_EN
    if (lock_hold && (lock_own ? m1_req : m0_req)) begin
      pick_m1 = lock_own;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 2'b00;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      cnt       <= '0;
      last      <= 1'b1;
`ifdef MEM_ARB_LOCK_EN
      lock_hold <= 1'b0;
      lock_own  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef MEM_ARB_LOCK_EN
          lock_hold <= 1'b0;
`endif
          if (win_valid) begin
            gnt       <= pick_m1 ? 2'b10 : 2'b01;
            mem_cs    <= 1'b1;
            mem_we    <= pick_m1 ? m1_we : m0_we;
            mem_addr  <= pick_m1 ? m1_addr : m0_addr;
            mem_wdata <= pick_m1 ? m1_wdata : m0_wdata;
            cnt       <= CNT_W'(WAIT_STATES);
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            if (!mem_we) begin
              rdata <= mem_rdata;
            end
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0_ack    <= gnt[0];
            m1_ack    <= gnt[1];
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          gnt    <= 2'b00;
          state  <= IDLE;
`ifdef MEM_ARB_LOCK_EN
          // A locked owner keeps its priority slot, so the alternation resumes where it left off.
          lock_hold <= owner_lock;
          lock_own  <= gnt[1];
          if (!owner_lock) begin
            last <= gnt[1];
          end
`else
          last <= gnt[1];
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
